// File: rtl/awg_pkg.sv
// Shared definitions for the AWG sequencer: wave codes, table entry layout,
// FSM encoding and the saturating sweep adder.
package awg_pkg;

   localparam logic [2:0] WAVE_SAW  = 3'd0;
   localparam logic [2:0] WAVE_TRI  = 3'd1;
   localparam logic [2:0] WAVE_SQR  = 3'd2;
   localparam logic [2:0] WAVE_SIN  = 3'd3;
   localparam logic [2:0] WAVE_RAND = 3'd4;
   localparam logic [2:0] WAVE_OFF  = 3'd7;

   localparam int WAVE_W  = 3;
   localparam int FREQ_W  = 12;
   localparam int STEP_W  = 8;
   localparam int AMP_W   = 3;
   localparam int PHASE_W = 8;
   localparam int DWELL_W = 8;
   localparam int ENTRY_W = WAVE_W + FREQ_W + STEP_W + AMP_W + PHASE_W + DWELL_W;

   // Field order matches the cfg_wdata packing, MSB first.
   typedef struct packed {
      logic [WAVE_W-1:0]  wave;
      logic [FREQ_W-1:0]  freq;
      logic [STEP_W-1:0]  step;
      logic [AMP_W-1:0]   amp;
      logic [PHASE_W-1:0] phase;
      logic [DWELL_W-1:0] dwell;
   } entry_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DWELL = 2'd2,
      ST_NEXT  = 2'd3
   } fsm_t;

   function automatic logic [FREQ_W-1:0] sat_add(input logic [FREQ_W-1:0] a,
                                                 input logic [STEP_W-1:0] b);
      logic [FREQ_W:0] sum;
      sum = {1'b0, a} + {{(FREQ_W + 1 - STEP_W){1'b0}}, b};
      return sum[FREQ_W] ? {FREQ_W{1'b1}} : sum[FREQ_W-1:0];
   endfunction

endpackage

// File: rtl/awg_tick_gen.sv
// Dwell/sweep prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// wrap cycle as a one-cycle tick. clr holds the count at zero.
module awg_tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      tick     = !clr && (cnt_reg == CNT_MAX);
      cnt_next = (clr || tick) ? '0 : cnt_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_reg <= '0;
      else        cnt_reg <= cnt_next;
   end

endmodule

// File: rtl/awg_seq_ctrl.sv
// Table-driven sequencer feeding sig_gen: plays entries 0..last_idx, each for
// max(dwell,1) ticks with an optional saturating frequency sweep.
module awg_seq_ctrl
   import awg_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = 3,
   parameter int TICK_DIV = 50000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [ADDR_W-1:0]  cfg_addr,
   input  logic [ENTRY_W-1:0] cfg_wdata,
   input  logic [ADDR_W-1:0]  last_idx,
   input  logic               loop_en,
   input  logic               start,
   input  logic               stop,
   output logic [2:0]         state,
   output logic [11:0]        state_freq,
   output logic [2:0]         state_amp,
   output logic [7:0]         state_phase,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  cur_idx
);

   entry_t tbl_mem [DEPTH];
   entry_t rd_entry;

   fsm_t               fsm_reg, fsm_next;
   logic [ADDR_W-1:0]  idx_reg, idx_next;
   logic [WAVE_W-1:0]  wave_reg, wave_next;
   logic [FREQ_W-1:0]  freq_reg, freq_next;
   logic [AMP_W-1:0]   amp_reg, amp_next;
   logic [PHASE_W-1:0] phase_reg, phase_next;
   logic [STEP_W-1:0]  step_reg, step_next;
   logic [DWELL_W-1:0] dwell_reg, dwell_next;
   logic [DWELL_W-1:0] tick_cnt_reg, tick_cnt_next;
   logic               done_reg, done_next;
   logic [DWELL_W-1:0] dwell_eff;
   logic               tick;
   logic               dwell_hit;

   // Writes land at the edge, so a LOAD in the same cycle still sees old data.
   always_ff @(posedge clk) begin
      if (cfg_we) tbl_mem[cfg_addr] <= entry_t'(cfg_wdata);
   end

   assign rd_entry = tbl_mem[idx_reg];

   awg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fsm_reg != ST_DWELL),
      .tick  (tick)
   );

   assign dwell_eff = (dwell_reg == '0) ? DWELL_W'(1) : dwell_reg;
   assign dwell_hit = tick && ((tick_cnt_reg + 1'b1) >= dwell_eff);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_reg <= ST_IDLE;
      else        fsm_reg <= fsm_next;
   end

   always_comb begin
      fsm_next = fsm_reg;
      if (stop) begin
         fsm_next = ST_IDLE;
      end else if (start) begin
         fsm_next = ST_LOAD;
      end else begin
         case (fsm_reg)
            ST_IDLE:  fsm_next = ST_IDLE;
            ST_LOAD:  fsm_next = ST_DWELL;
            ST_DWELL: if (dwell_hit) fsm_next = ST_NEXT;
            ST_NEXT:  fsm_next = (idx_reg < last_idx || loop_en) ? ST_LOAD : ST_IDLE;
            default:  fsm_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      idx_next      = idx_reg;
      wave_next     = wave_reg;
      freq_next     = freq_reg;
      amp_next      = amp_reg;
      phase_next    = phase_reg;
      step_next     = step_reg;
      dwell_next    = dwell_reg;
      tick_cnt_next = tick_cnt_reg;
      done_next     = 1'b0;
      if (stop) begin
         wave_next = WAVE_OFF;
      end else if (start) begin
         idx_next = '0;
      end else begin
         case (fsm_reg)
            ST_LOAD: begin
               wave_next     = rd_entry.wave;
               freq_next     = rd_entry.freq;
               amp_next      = rd_entry.amp;
               phase_next    = rd_entry.phase;
               step_next     = rd_entry.step;
               dwell_next    = rd_entry.dwell;
               tick_cnt_next = '0;
            end
            ST_DWELL: begin
               if (tick) begin
                  freq_next     = sat_add(freq_reg, step_reg);
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
            ST_NEXT: begin
               if (idx_reg < last_idx) begin
                  idx_next = idx_reg + 1'b1;
               end else if (loop_en) begin
                  idx_next = '0;
               end else begin
                  done_next = 1'b1;
                  wave_next = WAVE_OFF;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg      <= '0;
         wave_reg     <= WAVE_OFF;
         freq_reg     <= '0;
         amp_reg      <= '0;
         phase_reg    <= '0;
         step_reg     <= '0;
         dwell_reg    <= '0;
         tick_cnt_reg <= '0;
         done_reg     <= 1'b0;
      end else begin
         idx_reg      <= idx_next;
         wave_reg     <= wave_next;
         freq_reg     <= freq_next;
         amp_reg      <= amp_next;
         phase_reg    <= phase_next;
         step_reg     <= step_next;
         dwell_reg    <= dwell_next;
         tick_cnt_reg <= tick_cnt_next;
         done_reg     <= done_next;
      end
   end

   assign state       = wave_reg;
   assign state_freq  = freq_reg;
   assign state_amp   = amp_reg;
   assign state_phase = phase_reg;
   assign busy        = (fsm_reg != ST_IDLE);
   assign done        = done_reg;
   assign cur_idx     = idx_reg;

endmodule

// File: tb/tb_awg_seq_ctrl.sv
// Scoreboard bench for awg_seq_ctrl with TICK_DIV=4: stimulus queues expected
// output changes (cycle offset from the triggering edge), a monitor pops them.
module tb_awg_seq_ctrl;
   import awg_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [41:0] cfg_wdata = '0;
   logic [2:0]  last_idx = '0;
   logic        loop_en = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [2:0]  state;
   logic [11:0] state_freq;
   logic [2:0]  state_amp;
   logic [7:0]  state_phase;
   logic        busy;
   logic        done;
   logic [2:0]  cur_idx;

   awg_seq_ctrl #(.DEPTH(8), .ADDR_W(3), .TICK_DIV(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_wdata   (cfg_wdata),
      .last_idx    (last_idx),
      .loop_en     (loop_en),
      .start       (start),
      .stop        (stop),
      .state       (state),
      .state_freq  (state_freq),
      .state_amp   (state_amp),
      .state_phase (state_phase),
      .busy        (busy),
      .done        (done),
      .cur_idx     (cur_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          tag;
      int          n;
      logic [2:0]  st;
      logic [11:0] f;
      logic [2:0]  a;
      logic [7:0]  p;
      logic        d;
      logic        b;
      logic [2:0]  i;
   } exp_t;

   exp_t        q[$];
   int          n_err = 0;
   int          n_checks = 0;
   int          cyc = 0;
   int          t0 = 0;
   logic        mon_en = 1'b0;
   logic [26:0] prev_snap = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [26:0] snap;
      exp_t e;
      snap = {state, state_freq, state_amp, state_phase, done};
      if (mon_en && snap !== prev_snap) begin
         n_checks++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event n=%0d state=%0d freq=%0d amp=%0d phase=%0h done=%0b busy=%0b idx=%0d",
                     cyc - t0, state, state_freq, state_amp, state_phase, done, busy, cur_idx);
         end else begin
            e = q.pop_front();
            if ((cyc - t0) != e.n || state !== e.st || state_freq !== e.f || state_amp !== e.a ||
                state_phase !== e.p || done !== e.d || busy !== e.b || cur_idx !== e.i) begin
               n_err++;
               $display("FAIL evt tag=%0d got n=%0d state=%0d freq=%0d amp=%0d phase=%0h done=%0b busy=%0b idx=%0d want n=%0d state=%0d freq=%0d amp=%0d phase=%0h done=%0b busy=%0b idx=%0d",
                        e.tag, cyc - t0, state, state_freq, state_amp, state_phase, done, busy, cur_idx,
                        e.n, e.st, e.f, e.a, e.p, e.d, e.b, e.i);
            end else begin
               $display("ok  evt tag=%0d n=%0d state=%0d freq=%0d amp=%0d phase=%0h done=%0b busy=%0b idx=%0d",
                        e.tag, e.n, state, state_freq, state_amp, state_phase, done, busy, cur_idx);
            end
         end
      end
      prev_snap = snap;
   end

   function automatic logic [41:0] mk(input logic [2:0] w, input logic [11:0] f, input logic [7:0] s,
                                      input logic [2:0] a, input logic [7:0] p, input logic [7:0] d);
      return {w, f, s, a, p, d};
   endfunction

   task automatic push(input int tag, input int n, input logic [2:0] st, input logic [11:0] f,
                       input logic [2:0] a, input logic [7:0] p, input logic d, input logic b,
                       input logic [2:0] i);
      exp_t e;
      e.tag = tag; e.n = n; e.st = st; e.f = f; e.a = a; e.p = p; e.d = d; e.b = b; e.i = i;
      q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end else begin
         $display("ok  %s = %0d", nm, act);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [2:0] addr, input logic [41:0] data);
      cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
      step_clk();
      cfg_we = 1'b0;
   endtask

   // Caller is at posedge+1; the next edge samples the pulse and becomes offset 0.
   task automatic pulse_start();
      t0 = cyc + 1;
      start = 1'b1;
      step_clk();
      start = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int k = 0; k < budget && q.size() > 0; k++) @(negedge clk);
      if (q.size() > 0) begin
         n_checks++;
         n_err++;
         $display("FAIL drain_timeout pending=%0d", q.size());
         q.delete();
      end
      step_clk();
   endtask

   task automatic quiet(input int ncyc);
      repeat (ncyc) step_clk();
   endtask

   logic [41:0] ent_sin, ent_sqr;

   initial begin
      ent_sin = mk(WAVE_SIN, 12'd100, 8'd0, 3'd5, 8'h40, 8'd3);
      ent_sqr = mk(WAVE_SQR, 12'd200, 8'd0, 3'd2, 8'h80, 8'd2);

      repeat (3) step_clk();
      chk("rst_state", 32'(state), 32'd7);
      chk("rst_freq", 32'(state_freq), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_idx", 32'(cur_idx), 32'd0);
      rst_n = 1'b1;
      step_clk();

      // Reset asserted mid-DWELL
      cfg_write(3'd0, ent_sin);
      cfg_write(3'd1, ent_sqr);
      last_idx = 3'd1;
      loop_en = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      step_clk();
      push(1, 1, WAVE_SIN, 12'd100, 3'd5, 8'h40, 1'b0, 1'b1, 3'd0);
      pulse_start();
      repeat (6) step_clk();
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'd7);
      chk("arst_freq", 32'(state_freq), 32'd0);
      chk("arst_amp", 32'(state_amp), 32'd0);
      chk("arst_phase", 32'(state_phase), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_idx", 32'(cur_idx), 32'd0);
      chk("arst_q_empty", 32'(q.size()), 32'd0);
      repeat (2) step_clk();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      step_clk();

      // Single-shot two entries
      push(2, 1,  WAVE_SIN, 12'd100, 3'd5, 8'h40, 1'b0, 1'b1, 3'd0);
      push(2, 15, WAVE_SQR, 12'd200, 3'd2, 8'h80, 1'b0, 1'b1, 3'd1);
      push(2, 24, WAVE_OFF, 12'd200, 3'd2, 8'h80, 1'b1, 1'b0, 3'd1);
      push(2, 25, WAVE_OFF, 12'd200, 3'd2, 8'h80, 1'b0, 1'b0, 3'd1);
      pulse_start();
      wait_drain(200);
      quiet(10);

      // Sweep saturation
      cfg_write(3'd0, mk(WAVE_SAW, 12'd4090, 8'd5, 3'd3, 8'h11, 8'd3));
      last_idx = 3'd0;
      push(3, 1,  WAVE_SAW, 12'd4090, 3'd3, 8'h11, 1'b0, 1'b1, 3'd0);
      push(3, 5,  WAVE_SAW, 12'd4095, 3'd3, 8'h11, 1'b0, 1'b1, 3'd0);
      push(3, 14, WAVE_OFF, 12'd4095, 3'd3, 8'h11, 1'b1, 1'b0, 3'd0);
      push(3, 15, WAVE_OFF, 12'd4095, 3'd3, 8'h11, 1'b0, 1'b0, 3'd0);
      pulse_start();
      wait_drain(200);
      quiet(10);

      // Looped playback, then stop
      cfg_write(3'd0, ent_sin);
      last_idx = 3'd1;
      loop_en = 1'b1;
      push(4, 1,  WAVE_SIN, 12'd100, 3'd5, 8'h40, 1'b0, 1'b1, 3'd0);
      push(4, 15, WAVE_SQR, 12'd200, 3'd2, 8'h80, 1'b0, 1'b1, 3'd1);
      push(4, 25, WAVE_SIN, 12'd100, 3'd5, 8'h40, 1'b0, 1'b1, 3'd0);
      push(4, 39, WAVE_SQR, 12'd200, 3'd2, 8'h80, 1'b0, 1'b1, 3'd1);
      push(4, 49, WAVE_SIN, 12'd100, 3'd5, 8'h40, 1'b0, 1'b1, 3'd0);
      pulse_start();
      wait_drain(200);
      t0 = cyc + 1;
      push(4, 0, WAVE_OFF, 12'd100, 3'd5, 8'h40, 1'b0, 1'b0, 3'd0);
      stop = 1'b1;
      step_clk();
      stop = 1'b0;
      wait_drain(50);
      quiet(20);
      loop_en = 1'b0;

      // start and stop together stay idle
      start = 1'b1;
      stop = 1'b1;
      step_clk();
      start = 1'b0;
      stop = 1'b0;
      chk("startstop_busy", 32'(busy), 32'd0);
      chk("startstop_state", 32'(state), 32'd7);
      quiet(10);

      // dwell=0 lasts one tick
      cfg_write(3'd0, mk(WAVE_TRI, 12'd300, 8'd0, 3'd1, 8'h22, 8'd0));
      last_idx = 3'd0;
      push(5, 1, WAVE_TRI, 12'd300, 3'd1, 8'h22, 1'b0, 1'b1, 3'd0);
      push(5, 6, WAVE_OFF, 12'd300, 3'd1, 8'h22, 1'b1, 1'b0, 3'd0);
      push(5, 7, WAVE_OFF, 12'd300, 3'd1, 8'h22, 1'b0, 1'b0, 3'd0);
      pulse_start();
      wait_drain(100);
      quiet(10);

      // Rewrite entry 1 while entry 0 plays
      cfg_write(3'd0, ent_sin);
      last_idx = 3'd1;
      push(6, 1,  WAVE_SIN,  12'd100,  3'd5, 8'h40, 1'b0, 1'b1, 3'd0);
      push(6, 15, WAVE_RAND, 12'h555,  3'd6, 8'h99, 1'b0, 1'b1, 3'd1);
      push(6, 19, WAVE_RAND, 12'h556,  3'd6, 8'h99, 1'b0, 1'b1, 3'd1);
      push(6, 20, WAVE_OFF,  12'h556,  3'd6, 8'h99, 1'b1, 1'b0, 3'd1);
      push(6, 21, WAVE_OFF,  12'h556,  3'd6, 8'h99, 1'b0, 1'b0, 3'd1);
      pulse_start();
      repeat (3) step_clk();
      cfg_write(3'd1, mk(WAVE_RAND, 12'h555, 8'd1, 3'd6, 8'h99, 8'd1));
      wait_drain(200);
      quiet(10);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

endmodule
